// File: rtl/psram_line_reader.sv
// psram_line_reader: fetches LINE_WORDS consecutive words from the PSRAM wrapper
// per line_start and buffers them in a first-word-fall-through pixel FIFO.
module psram_line_reader #(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 16,
  parameter int LINE_WORDS  = 640,
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              active,
  output logic              underrun,
  output logic [7:0]        retry_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WL_W  = $clog2(LINE_WORDS + 1);
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [WL_W-1:0]  LINE_C   = WL_W'(LINE_WORDS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DATA} state_t;

  state_t             state, state_next;
  logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [WL_W-1:0]    words_left;
  logic [TMR_W-1:0]   timer;
  logic               accept, strobe, capture, timeout;
  logic               has_space, last_word, push, pop;

  // A slot is reserved at issue time, so the single outstanding capture always fits.
  assign has_space = (count < DEPTH_C);
  assign last_word = (words_left == WL_W'(1));
  assign push      = capture;
  assign pix_valid = (count != '0);
  assign pop       = pix_valid & pix_ready;
  assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : '0;
  assign mem_read  = strobe;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and the one-cycle control pulses driving the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    strobe     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_busy && has_space) begin
          strobe     = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (mem_busy) begin
          state_next = WAIT_DATA;
        end else if (timer == '0) begin
          timeout    = 1'b1;
          state_next = ISSUE;
        end
      end
      WAIT_DATA: begin
        if (!mem_busy) begin
          capture    = 1'b1;
          state_next = last_word ? IDLE : ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address, word counter, ack timer, activity flag and retry statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr   <= '0;
      words_left <= '0;
      timer      <= '0;
      active     <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      if (accept) begin
        mem_addr   <= line_base;
        words_left <= LINE_C;
        active     <= 1'b1;
      end
      if (strobe) begin
        timer <= TMR_LOAD;
      end else if (state == WAIT_ACK && timer != '0) begin
        timer <= timer - 1'b1;
      end
      if (timeout && retry_cnt != 8'hFF) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
      if (capture) begin
        mem_addr   <= mem_addr + 1'b1;
        words_left <= words_left - 1'b1;
        if (last_word) active <= 1'b0;
      end
    end
  end

  // Sticky underrun: consumer asked for a pixel the fetch has not delivered yet.
  always_ff @(posedge clk) begin
    if (rst)                                    underrun <= 1'b0;
    else if (accept)                            underrun <= 1'b0;
    else if (active && pix_ready && !pix_valid) underrun <= 1'b1;
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_dout;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_line_reader.sv
// Testbench for psram_line_reader: behavioural PSRAM wrapper, pop recorder,
// table-driven line fetches, hand-written corner sequences and random pacing.
module tb_psram_line_reader;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic [21:0] line_base = '0;
  logic        pix_ready = 1'b0;
  logic        mem_busy = 1'b0;
  logic [15:0] mem_dout = '0;
  logic        mem_read;
  logic [21:0] mem_addr;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        active;
  logic        underrun;
  logic [7:0]  retry_cnt;

  psram_line_reader #(
    .ADDR_W(22), .DATA_W(16), .LINE_WORDS(LW), .FIFO_DEPTH(16), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .line_base(line_base),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_busy(mem_busy), .mem_dout(mem_dout),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .active(active), .underrun(underrun), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;

  int          strobes = 0;
  int          ignore_at = -1;
  int          busy_strobes = 0;
  int          busy_cnt = 0;
  logic [15:0] pend = '0;
  logic [21:0] strobe_addr [0:1023];

  logic [15:0] popped [0:1023];
  int          pop_wr = 0;
  int          pop_rd = 0;
  logic [15:0] exp_q [$];

  // Wrapper model: busy one cycle after a strobe, falls six cycles later with dout=addr[15:0].
  always @(posedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        mem_busy <= 1'b0;
        mem_dout <= pend;
      end
    end
    if (mem_read) begin
      if (mem_busy) busy_strobes++;
      if (strobes < 1024) strobe_addr[strobes] = mem_addr;
      if (strobes != ignore_at) begin
        mem_busy <= 1'b1;
        busy_cnt = 6;
        pend     = mem_addr[15:0];
      end
      strobes++;
    end
  end

  // Record every word the consumer actually pops.
  always @(negedge clk) begin
    if (!rst && pix_valid && pix_ready && pop_wr < 1024) begin
      popped[pop_wr] = pix_data;
      pop_wr++;
    end
  end

  // Hard stop in case something escapes the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [21:0] base;
    logic [21:0] exp_addr [4];
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input string msg);
    checks++;
    fails++;
    $display("[TB] FAIL %s: %s", name, msg);
  endtask

  // Reference: word k of a line is the low half of (base + k) modulo 2^22.
  function automatic logic [15:0] word_at(input logic [21:0] base, input int k);
    logic [21:0] a;
    a = base + 22'(k);
    return a[15:0];
  endfunction

  task automatic applyStimulus(input logic [21:0] base, input bit expect_accept);
    line_base  = base;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    if (expect_accept) begin
      for (int k = 0; k < LW; k++) exp_q.push_back(word_at(base, k));
    end
    checkOutput("active_after_start", 32'(active), 32'd1);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while (active && n < budget) begin
      tick();
      n++;
    end
    if (active) failNow(name, "active never fell within cycle budget");
  endtask

  task automatic waitStrobes(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (strobes < target && n < budget) begin
      tick();
      n++;
    end
    if (strobes < target) failNow(name, "expected mem_read pulse never came");
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    pix_ready = 1'b1;
    while (pix_valid && n < 64) begin
      tick();
      n++;
    end
    if (pix_valid) failNow(name, "FIFO did not drain");
  endtask

  task automatic comparePops(input string name);
    while (pop_rd < pop_wr) begin
      if (exp_q.size() == 0) failNow(name, "popped a word the model did not expect");
      else checkOutput(name, 32'(popped[pop_rd]), 32'(exp_q.pop_front()));
      pop_rd++;
    end
    checkOutput({name, "_missing"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          s0;
    logic [21:0] b;

    vecs[0].base = 22'h000100;
    vecs[0].exp_addr = '{22'h000100, 22'h000101, 22'h000102, 22'h000103};
    vecs[1].base = 22'h3FFFFE;
    vecs[1].exp_addr = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000, 22'h000001};
    vecs[2].base = 22'h1ABCDE;
    vecs[2].exp_addr = '{22'h1ABCDE, 22'h1ABCDF, 22'h1ABCE0, 22'h1ABCE1};
    vecs[3].base = 22'h00FFFF;
    vecs[3].exp_addr = '{22'h00FFFF, 22'h010000, 22'h010001, 22'h010002};

    // Reset state
    repeat (3) tick();
    checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_pix_data", 32'(pix_data), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_retry_cnt", 32'(retry_cnt), 32'd0);
    rst = 1'b0;

    // Idle consumer requests do not count as underrun
    pix_ready = 1'b1;
    repeat (3) tick();
    checkOutput("idle_no_underrun", 32'(underrun), 32'd0);

    // Table-driven lines, including address wrap at the top of memory
    for (int i = 0; i < 4; i++) begin
      s0 = strobes;
      applyStimulus(vecs[i].base, 1'b1);
      waitIdle("t1_idle", 200);
      checkOutput("t1_strobe_count", 32'(strobes - s0), 32'd4);
      for (int k = 0; k < 4; k++)
        checkOutput("t1_strobe_addr", 32'(strobe_addr[s0 + k]), 32'(vecs[i].exp_addr[k]));
      drain("t1_drain");
      repeat (2) tick();
      comparePops("t1_pix_data");
    end

    // FIFO full: four lines stalled, the fifth holds until a slot frees
    pix_ready = 1'b0;
    s0 = strobes;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(22'($urandom), 1'b1);
      waitIdle("t2_idle", 200);
    end
    applyStimulus(22'($urandom), 1'b1);
    repeat (30) tick();
    checkOutput("t2_reads_when_full", 32'(strobes - s0), 32'd16);
    checkOutput("t2_no_pops", 32'(pop_wr - pop_rd), 32'd0);
    checkOutput("t2_valid_when_full", 32'(pix_valid), 32'd1);
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    repeat (30) tick();
    checkOutput("t2_one_more_read", 32'(strobes - s0), 32'd17);
    checkOutput("t2_one_pop", 32'(pop_wr - pop_rd), 32'd1);
    pix_ready = 1'b1;
    waitIdle("t2_finish", 300);
    drain("t2_drain");
    repeat (2) tick();
    comparePops("t2_pix_data");

    // Ignored strobe: timeout, retry counter, same address re-strobed
    s0 = strobes;
    ignore_at = strobes;
    applyStimulus(22'h000200, 1'b1);
    waitStrobes("t4_restrobe", s0 + 2, 60);
    checkOutput("t4_retry_cnt", 32'(retry_cnt), 32'd1);
    checkOutput("t4_first_addr", 32'(strobe_addr[s0]), 32'h200);
    checkOutput("t4_retry_addr", 32'(strobe_addr[s0 + 1]), 32'h200);
    waitIdle("t4_idle", 200);
    checkOutput("t4_retry_final", 32'(retry_cnt), 32'd1);
    drain("t4_drain");
    repeat (2) tick();
    comparePops("t4_pix_data");

    // Reset while the wrapper is mid-access
    b = 22'($urandom);
    applyStimulus(b, 1'b1);
    repeat (3) tick();
    checkOutput("t5_wrapper_busy", 32'(mem_busy), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("t5_active", 32'(active), 32'd0);
    checkOutput("t5_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("t5_mem_read", 32'(mem_read), 32'd0);
    checkOutput("t5_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("t5_retry_cnt", 32'(retry_cnt), 32'd0);
    checkOutput("t5_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    pop_rd = pop_wr;
    s0 = strobes;
    b = 22'($urandom);
    applyStimulus(b, 1'b1);
    waitStrobes("t5_new_strobe", s0 + 1, 30);
    checkOutput("t5_new_addr", 32'(strobe_addr[s0]), 32'(b));
    waitIdle("t5_idle", 200);
    drain("t5_drain");
    repeat (2) tick();
    comparePops("t5_pix_data");

    // Underrun stickiness and line_start ignored while active
    pix_ready = 1'b0;
    s0 = strobes;
    applyStimulus(22'h001000, 1'b1);
    pix_ready = 1'b1;
    tick();
    checkOutput("t6_underrun_set", 32'(underrun), 32'd1);
    applyStimulus(22'h002000, 1'b0);
    waitIdle("t6_idle", 200);
    checkOutput("t6_strobe_count", 32'(strobes - s0), 32'd4);
    checkOutput("t6_last_addr", 32'(strobe_addr[s0 + 3]), 32'h1003);
    drain("t6_drain");
    repeat (3) tick();
    checkOutput("t6_underrun_sticky", 32'(underrun), 32'd1);
    comparePops("t6_pix_data");
    applyStimulus(22'h003000, 1'b1);
    checkOutput("t6_underrun_cleared", 32'(underrun), 32'd0);
    waitIdle("t6_idle2", 200);
    drain("t6_drain2");
    repeat (2) tick();
    comparePops("t6_pix_data2");

    // Random bases with random consumer pacing
    for (int l = 0; l < 3; l++) begin
      int n;
      applyStimulus(22'($urandom), 1'b1);
      n = 0;
      while (active && n < 400) begin
        pix_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      if (active) failNow("t7_idle", "active never fell within cycle budget");
      drain("t7_drain");
      repeat (2) tick();
      comparePops("t7_pix_data");
    end

    checkOutput("no_strobe_while_busy", 32'(busy_strobes), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
